// File: rtl/rf_port_if.sv
// rf_port_if: requester-side bundle of the register-file access port.
// Requester i owns bit i of each one-hot field, addr bits [3i+2:3i] and wdata bits [8i+7:8i].
interface rf_port_if #(
  parameter int unsigned NREQ = 3
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   req_we;
  logic [3*NREQ-1:0] req_addr;
  logic [8*NREQ-1:0] req_wdata;
  logic [NREQ-1:0]   req_lock;
  logic [NREQ-1:0]   rsp_valid;
  logic [7:0]        rsp_rdata;

  // Requesters drive the request fields and observe grant/response
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_lock,
    input  req_ready, rsp_valid, rsp_rdata
  );

  // The arbiter observes requests and drives grant/response
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_lock,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/rf_port_arbiter.sv
// rf_port_arbiter: 8 x 8-bit register file behind a single round-robin access port.
// A granted requester may lock the port; the lock is force-released after LOCK_MAX cycles.
// req_ready and grant_id are same-cycle decodes of the grant; all other outputs are flops.
// Optional macro RF_ZERO_REG_EN: r0 reads as zero and ignores writes.
module rf_port_arbiter #(
  parameter int unsigned NREQ     = 3,
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  rf_port_if.slave    port,
  output logic [1:0]  grant_id,
  output logic        locked,
  output logic        lock_abort,
  output logic [63:0] reg_file_out
);
  localparam int unsigned IDX_W = 2;
  localparam int unsigned NREG  = 8;
  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 3;
  localparam int unsigned CNT_W = 8;

  typedef enum logic {S_IDLE, S_LOCKED} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;       // last winner; also the lock owner while locked
  logic [IDX_W-1:0] gid_q, gid_d;       // last granted index, shown while idle
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             abort_q, abort_d;
  logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic [DW-1:0]    rf_q [NREG];
  logic [DW-1:0]    rf_d [NREG];

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic             gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             g_we;
  logic             g_lock;
  logic [AW-1:0]    g_addr;
  logic [DW-1:0]    g_wdata;
  logic [NREQ-1:0]  ready_c;

  // Round-robin search: first valid requester upward from (last winner + 1), wrapping
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!win_found && port.req_valid[i] && (((32'(ptr_q) + k) % NREQ) == i)) begin
          win_found = 1'b1;
          win_idx   = IDX_W'(i);
        end
      end
    end
  end

  // Grant decision: open arbitration when idle, owner only when locked
  always_comb begin
    gnt     = 1'b0;
    gnt_idx = ptr_q;
    if (state_q == S_IDLE) begin
      gnt     = win_found;
      gnt_idx = win_idx;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (ptr_q == IDX_W'(i)) gnt = port.req_valid[i];
      end
    end
  end

  // Select the granted requester's fields and raise its ready
  always_comb begin
    g_we    = 1'b0;
    g_lock  = 1'b0;
    g_addr  = '0;
    g_wdata = '0;
    ready_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDX_W'(i)) begin
        g_we       = port.req_we[i];
        g_lock     = port.req_lock[i];
        g_addr     = port.req_addr[AW*i +: AW];
        g_wdata    = port.req_wdata[DW*i +: DW];
        ready_c[i] = gnt;
      end
    end
  end

  // Next state: execute the granted access and advance the lock FSM
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gid_d       = gid_q;
    cnt_d       = cnt_q;
    abort_d     = 1'b0;
    rsp_valid_d = '0;
    rdata_d     = rdata_q;
    for (int unsigned r = 0; r < NREG; r++) rf_d[r] = rf_q[r];

    if (gnt) begin
      ptr_d = gnt_idx;
      gid_d = gnt_idx;
      if (g_we) begin
`ifdef RF_ZERO_REG_EN
        if (g_addr != '0) rf_d[g_addr] = g_wdata;
`else
        rf_d[g_addr] = g_wdata;
`endif
      end else begin
        rdata_d     = rf_q[g_addr];
        rsp_valid_d = ready_c;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (gnt && g_lock) begin
          state_d = S_LOCKED;
          cnt_d   = '0;
        end
      end
      S_LOCKED: begin
        if (cnt_q == CNT_W'(LOCK_MAX - 1)) begin
          // Budget exhausted; a voluntary release in the same cycle is not an abort
          state_d = S_IDLE;
          abort_d = !(gnt && !g_lock);
        end else if (gnt && !g_lock) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset discards any lock or read in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= IDX_W'(NREQ - 1);
      gid_q       <= '0;
      cnt_q       <= '0;
      abort_q     <= 1'b0;
      rsp_valid_q <= '0;
      rdata_q     <= '0;
      for (int unsigned r = 0; r < NREG; r++) rf_q[r] <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gid_q       <= gid_d;
      cnt_q       <= cnt_d;
      abort_q     <= abort_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      for (int unsigned r = 0; r < NREG; r++) rf_q[r] <= rf_d[r];
    end
  end

  // Flatten the register file for the debug monitor
  always_comb begin
    reg_file_out = '0;
    for (int unsigned r = 0; r < NREG; r++) reg_file_out[DW*r +: DW] = rf_q[r];
  end

  assign port.req_ready = ready_c;
  assign port.rsp_valid = rsp_valid_q;
  assign port.rsp_rdata = rdata_q;
  assign grant_id       = gnt ? gnt_idx : gid_q;
  assign locked         = (state_q == S_LOCKED);
  assign lock_abort     = abort_q;
endmodule

// File: tb/tb_rf_port_arbiter.sv
// tb_rf_port_arbiter: vector table, lock/reset corner sequences and random traffic,
// every cycle also compared against a behavioural model of the arbitration rules.
module tb_rf_port_arbiter;
  localparam int unsigned NREQ     = 3;
  localparam int unsigned LOCK_MAX = 8;
`ifdef RF_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  grant_id;
  logic        locked;
  logic        lock_abort;
  logic [63:0] reg_file_out;

  rf_port_if #(.NREQ(NREQ)) port ();

  rf_port_arbiter #(.NREQ(NREQ), .LOCK_MAX(LOCK_MAX)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .port         (port),
    .grant_id     (grant_id),
    .locked       (locked),
    .lock_abort   (lock_abort),
    .reg_file_out (reg_file_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: register array, last winner, lock owner and its age
  logic [7:0]      m_regs [8];
  int              m_last;
  int              m_owner;
  int              m_age;
  int              m_gid;
  logic [NREQ-1:0] m_rsp_valid;
  logic [7:0]      m_rdata;
  logic            m_abort;

  task automatic model_reset();
    for (int r = 0; r < 8; r++) m_regs[r] = 8'h00;
    m_last      = NREQ - 1;
    m_owner     = -1;
    m_age       = 0;
    m_gid       = 0;
    m_rsp_valid = '0;
    m_rdata     = 8'h00;
    m_abort     = 1'b0;
  endtask

  // Outputs sampled at the falling edge of the most recent cycle
  logic [NREQ-1:0] s_ready, s_rsp_valid;
  logic [1:0]      s_gid;
  logic [7:0]      s_rdata;
  logic            s_locked, s_abort;
  logic [63:0]     s_rf;

  // One clock: sample mid-cycle, compare against the model, advance model, step past the edge
  task automatic do_cycle();
    int              g;
    logic [NREQ-1:0] v, exp_ready, next_rsp;
    logic [63:0]     flat;
    logic            we, lk, rel, next_abort;
    logic [2:0]      addr;
    logic [7:0]      wdata;
    @(negedge clk);
    s_ready     = port.req_ready;
    s_rsp_valid = port.rsp_valid;
    s_rdata     = port.rsp_rdata;
    s_gid       = grant_id;
    s_locked    = locked;
    s_abort     = lock_abort;
    s_rf        = reg_file_out;

    flat = '0;
    for (int r = 0; r < 8; r++) flat[8*r +: 8] = m_regs[r];
    check("model rsp_valid", 64'(s_rsp_valid), 64'(m_rsp_valid));
    check("model rsp_rdata", 64'(s_rdata), 64'(m_rdata));
    check("model locked", 64'(s_locked), 64'(m_owner >= 0));
    check("model lock_abort", 64'(s_abort), 64'(m_abort));
    check("model reg_file_out", s_rf, flat);

    v = port.req_valid;
    g = -1;
    if (m_owner < 0) begin
      for (int k = 1; k <= int'(NREQ); k++) begin
        int c;
        c = (m_last + k) % int'(NREQ);
        if (g < 0 && (v >> c) & 1) g = c;
      end
    end else if ((v >> m_owner) & 1) begin
      g = m_owner;
    end
    exp_ready = (g >= 0) ? (NREQ'(1) << g) : '0;
    check("model req_ready", 64'(s_ready), 64'(exp_ready));
    check("model grant_id", 64'(s_gid), 64'((g >= 0) ? g : m_gid));

    next_rsp   = '0;
    next_abort = 1'b0;
    lk         = 1'b0;
    if (g >= 0) begin
      m_gid = g;
      we    = 1'((port.req_we >> g) & 1);
      lk    = 1'((port.req_lock >> g) & 1);
      addr  = 3'(port.req_addr >> (3*g));
      wdata = 8'(port.req_wdata >> (8*g));
      if (we) begin
        if (!(ZERO_REG && addr == 3'd0)) m_regs[addr] = wdata;
      end else begin
        m_rdata  = (ZERO_REG && addr == 3'd0) ? 8'h00 : m_regs[addr];
        next_rsp = exp_ready;
      end
    end
    if (m_owner >= 0) begin
      rel = (g >= 0) && !lk;
      if (m_age == int'(LOCK_MAX) - 1) begin
        m_owner    = -1;
        next_abort = !rel;
      end else if (rel) begin
        m_owner = -1;
      end else begin
        m_age++;
      end
    end else if (g >= 0 && lk) begin
      m_owner = g;
      m_age   = 0;
    end
    if (g >= 0 && m_owner < 0) m_last = g;
    if (g >= 0 && m_owner >= 0) m_last = m_owner;
    m_rsp_valid = next_rsp;
    m_abort     = next_abort;

    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic we, input logic [2:0] a,
                         input logic [7:0] d, input logic lk);
    port.req_valid[i]         = v;
    port.req_we[i]            = we;
    port.req_addr[3*i +: 3]   = a;
    port.req_wdata[8*i +: 8]  = d;
    port.req_lock[i]          = lk;
  endtask

  task automatic clear_reqs();
    port.req_valid = '0;
    port.req_we    = '0;
    port.req_addr  = '0;
    port.req_wdata = '0;
    port.req_lock  = '0;
  endtask

  typedef struct {
    logic [2:0]  valid;
    logic [2:0]  we;
    logic [8:0]  addr;
    logic [23:0] wdata;
    logic [2:0]  exp_ready;
    logic [1:0]  exp_gid;
    logic [2:0]  exp_rsp;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t tbl [14];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // valid, we, addr, wdata, exp_ready, exp_gid, exp_rsp_valid, exp_rdata
    tbl[0]  = '{3'b001, 3'b001, 9'o003, 24'h00005A, 3'b001, 2'd0, 3'b000, 8'h00};
    tbl[1]  = '{3'b001, 3'b000, 9'o003, 24'h000000, 3'b001, 2'd0, 3'b000, 8'h00};
    tbl[2]  = '{3'b000, 3'b000, 9'o000, 24'h000000, 3'b000, 2'd0, 3'b001, 8'h5A};
    tbl[3]  = '{3'b100, 3'b100, 9'o700, 24'h770000, 3'b100, 2'd2, 3'b000, 8'h5A};
    tbl[4]  = '{3'b111, 3'b111, 9'o654, 24'h121110, 3'b001, 2'd0, 3'b000, 8'h5A};
    tbl[5]  = '{3'b111, 3'b111, 9'o654, 24'h121110, 3'b010, 2'd1, 3'b000, 8'h5A};
    tbl[6]  = '{3'b111, 3'b111, 9'o654, 24'h121110, 3'b100, 2'd2, 3'b000, 8'h5A};
    tbl[7]  = '{3'b111, 3'b111, 9'o654, 24'h121110, 3'b001, 2'd0, 3'b000, 8'h5A};
    tbl[8]  = '{3'b111, 3'b111, 9'o654, 24'h121110, 3'b010, 2'd1, 3'b000, 8'h5A};
    tbl[9]  = '{3'b111, 3'b111, 9'o654, 24'h121110, 3'b100, 2'd2, 3'b000, 8'h5A};
    tbl[10] = '{3'b010, 3'b000, 9'o050, 24'h000000, 3'b010, 2'd1, 3'b000, 8'h5A};
    tbl[11] = '{3'b001, 3'b000, 9'o004, 24'h000000, 3'b001, 2'd0, 3'b010, 8'h11};
    tbl[12] = '{3'b000, 3'b000, 9'o000, 24'h000000, 3'b000, 2'd0, 3'b001, 8'h10};
    tbl[13] = '{3'b000, 3'b000, 9'o000, 24'h000000, 3'b000, 2'd0, 3'b000, 8'h10};

    // Reset state
    rst_n = 1'b0;
    clear_reqs();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset req_ready", 64'(port.req_ready), 64'h0);
    check("reset rsp_valid", 64'(port.rsp_valid), 64'h0);
    check("reset rsp_rdata", 64'(port.rsp_rdata), 64'h0);
    check("reset grant_id", 64'(grant_id), 64'h0);
    check("reset locked", 64'(locked), 64'h0);
    check("reset lock_abort", 64'(lock_abort), 64'h0);
    check("reset reg_file_out", reg_file_out, 64'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Vector table: write/read, round-robin rotation, back-to-back reads
    for (int t = 0; t < 14; t++) begin
      port.req_valid = tbl[t].valid;
      port.req_we    = tbl[t].we;
      port.req_addr  = tbl[t].addr;
      port.req_wdata = tbl[t].wdata;
      port.req_lock  = '0;
      do_cycle();
      check($sformatf("vec%0d req_ready", t), 64'(s_ready), 64'(tbl[t].exp_ready));
      check($sformatf("vec%0d grant_id", t), 64'(s_gid), 64'(tbl[t].exp_gid));
      check($sformatf("vec%0d rsp_valid", t), 64'(s_rsp_valid), 64'(tbl[t].exp_rsp));
      check($sformatf("vec%0d rsp_rdata", t), 64'(s_rdata), 64'(tbl[t].exp_rdata));
    end
    check("table r3", 64'(s_rf[31:24]), 64'h5A);
    check("table reg_file_out", s_rf, 64'h7712_1110_5A00_0000);

    // Forced release: req1 holds the lock while req0/req2 wait
    clear_reqs();
    set_req(1, 1'b1, 1'b0, 3'd5, 8'h00, 1'b1);
    do_cycle();
    check("lockA entry ready", 64'(s_ready), 64'b010);
    set_req(0, 1'b1, 1'b1, 3'd1, 8'hA0, 1'b0);
    set_req(2, 1'b1, 1'b1, 3'd2, 8'hC2, 1'b0);
    for (int c = 0; c < int'(LOCK_MAX); c++) begin
      do_cycle();
      check($sformatf("lockA c%0d locked", c), 64'(s_locked), 64'h1);
      check($sformatf("lockA c%0d ready", c), 64'(s_ready), 64'b010);
      check($sformatf("lockA c%0d abort", c), 64'(s_abort), 64'h0);
    end
    set_req(1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    do_cycle();
    check("lockA after locked", 64'(s_locked), 64'h0);
    check("lockA after abort", 64'(s_abort), 64'h1);
    check("lockA after ready", 64'(s_ready), 64'b100);
    set_req(2, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    do_cycle();
    check("lockA abort width", 64'(s_abort), 64'h0);
    check("lockA next ready", 64'(s_ready), 64'b001);
    clear_reqs();

    // Voluntary release: req2 locks, three accesses, unlocking write
    set_req(2, 1'b1, 1'b1, 3'd6, 8'h01, 1'b1);
    do_cycle();
    check("lockB entry ready", 64'(s_ready), 64'b100);
    for (int c = 0; c < 2; c++) begin
      set_req(2, 1'b1, 1'b1, 3'd6, 8'(c + 2), 1'b1);
      do_cycle();
      check($sformatf("lockB c%0d locked", c), 64'(s_locked), 64'h1);
      check($sformatf("lockB c%0d ready", c), 64'(s_ready), 64'b100);
    end
    set_req(0, 1'b1, 1'b1, 3'd1, 8'h55, 1'b0);
    set_req(1, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
    set_req(2, 1'b1, 1'b1, 3'd6, 8'hE6, 1'b0);
    do_cycle();
    check("lockB release locked", 64'(s_locked), 64'h1);
    check("lockB release ready", 64'(s_ready), 64'b100);
    set_req(2, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    do_cycle();
    check("lockB after locked", 64'(s_locked), 64'h0);
    check("lockB after abort", 64'(s_abort), 64'h0);
    check("lockB resume ready", 64'(s_ready), 64'b001);
    check("lockB r6", 64'(s_rf[55:48]), 64'hE6);
    set_req(0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    do_cycle();
    clear_reqs();
    do_cycle();

    // Asynchronous reset mid-lock with a read response pending
    set_req(0, 1'b1, 1'b0, 3'd6, 8'h00, 1'b1);
    do_cycle();
    do_cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst locked", 64'(locked), 64'h0);
    check("rst rsp_valid", 64'(port.rsp_valid), 64'h0);
    check("rst reg_file_out", reg_file_out, 64'h0);
    check("rst lock_abort", 64'(lock_abort), 64'h0);
    clear_reqs();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) begin
      do_cycle();
      check($sformatf("rst post c%0d rsp_valid", c), 64'(s_rsp_valid), 64'h0);
      check($sformatf("rst post c%0d locked", c), 64'(s_locked), 64'h0);
    end

    // r0 write then read
    set_req(0, 1'b1, 1'b1, 3'd0, 8'hFF, 1'b0);
    do_cycle();
    check("r0 write ready", 64'(s_ready), 64'b001);
    set_req(0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
    do_cycle();
    clear_reqs();
    do_cycle();
    check("r0 read rsp_valid", 64'(s_rsp_valid), 64'b001);
    check("r0 read rdata", 64'(s_rdata), ZERO_REG ? 64'h00 : 64'hFF);

    // Random traffic; ungranted requests are held stable
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (!(port.req_valid[i] && !s_ready[i])) begin
          set_req(i, 1'($urandom_range(0, 99) < 60), 1'($urandom % 2), 3'($urandom % 8),
                  8'($urandom), 1'($urandom_range(0, 99) < 15));
        end
      end
      do_cycle();
    end
    clear_reqs();
    repeat (2) do_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
